// File: rtl/osd_pkg.sv
// osd_pkg: shared OSD types and constants.
// Contents:
//   osd_colour_t     4-bit OSD colour nibble
//   OSD_TRANSPARENT  colour value that selects normal (non-OSD) video
//   fifo_state_t     pixel FIFO release state (PRIME waits for fill, RUN releases)
package osd_pkg;

    typedef logic [3:0] osd_colour_t;

    localparam osd_colour_t OSD_TRANSPARENT = 4'h0;

    typedef enum logic {
        PRIME,
        RUN
    } fifo_state_t;

endpackage

// File: rtl/osd_pixel_fifo_if.sv
// osd_pixel_fifo_if: pixel FIFO bus between deserialiser/video timing and the FIFO.
// Signals:
//   osd_colour, write (active-low), line_start, pix_en   -> into the FIFO
//   pix_colour, pix_active, fifo_level, overflow, underflow -> out of the FIFO
//   ovf_count, udf_count -> out of the FIFO, only with OSD_PIXEL_FIFO_STATS_EN
// Modports: master drives the inputs and observes the outputs; slave is the FIFO.
interface osd_pixel_fifo_if
    import osd_pkg::*;
#(
    parameter int DEPTH = 16
);

    osd_colour_t                osd_colour;
    logic                       write;
    logic                       line_start;
    logic                       pix_en;
    osd_colour_t                pix_colour;
    logic                       pix_active;
    logic [$clog2(DEPTH):0]     fifo_level;
    logic                       overflow;
    logic                       underflow;
`ifdef OSD_PIXEL_FIFO_STATS_EN
    logic [15:0]                ovf_count;
    logic [15:0]                udf_count;

    modport master (
        output osd_colour, write, line_start, pix_en,
        input  pix_colour, pix_active, fifo_level, overflow, underflow, ovf_count, udf_count
    );

    modport slave (
        input  osd_colour, write, line_start, pix_en,
        output pix_colour, pix_active, fifo_level, overflow, underflow, ovf_count, udf_count
    );
`else
    modport master (
        output osd_colour, write, line_start, pix_en,
        input  pix_colour, pix_active, fifo_level, overflow, underflow
    );

    modport slave (
        input  osd_colour, write, line_start, pix_en,
        output pix_colour, pix_active, fifo_level, overflow, underflow
    );
`endif

endinterface

// File: rtl/osd_pixel_ram.sv
// osd_pixel_ram: DEPTH x 4 pixel storage, registered write port, asynchronous read port.
// Ports:
//   spi_clk  clock
//   we       write enable; waddr/wdata written on the rising edge
//   raddr    read address; rdata is the entry at raddr
module osd_pixel_ram
    import osd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          spi_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  osd_colour_t   wdata,
    input  logic [AW-1:0] raddr,
    output osd_colour_t   rdata
);

    osd_colour_t mem [DEPTH];

    always_ff @(posedge spi_clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/osd_pixel_fifo.sv
// osd_pixel_fifo: captures OSD colour nibbles on write strobes and releases them per pix_en.
// Ports:
//   spi_clk  sole clock, rising edge
//   reset    synchronous, active-high
//   bus      osd_pixel_fifo_if.slave: colour/write/line_start/pix_en in;
//            pix_colour/pix_active/fifo_level/overflow/underflow out
// Option: OSD_PIXEL_FIFO_STATS_EN adds saturating ovf_count/udf_count event counters.
module osd_pixel_fifo
    import osd_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int PRIME_LEVEL = 4
) (
    input logic             spi_clk,
    input logic             reset,
    osd_pixel_fifo_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    fifo_state_t   state, state_nxt;
    logic          write_d;
    logic [PW-1:0] wptr, rptr;
    logic [LW-1:0] level;
    osd_colour_t   head, pix_colour_q;
    logic          pix_active_q, overflow_q, underflow_q;
    logic          push, flush, pop_req, empty, full, pop, udf_evt, ovf_evt, do_write;

    assign push     = write_d && !bus.write;
    assign flush    = bus.line_start;
    assign empty    = level == '0;
    assign full     = level == LW'(DEPTH);
    // line_start wins over pix_en: no pop and no underflow in a flush cycle
    assign pop_req  = state == RUN && bus.pix_en && !flush;
    assign pop      = pop_req && !empty;
    assign udf_evt  = pop_req && empty;
    // a simultaneous pop frees a slot, and a flush empties the FIFO before the push lands
    assign do_write = push && (flush || !full || pop);
    assign ovf_evt  = push && !do_write;

    osd_pixel_ram #(.DEPTH(DEPTH)) u_ram (
        .spi_clk (spi_clk),
        .we      (do_write),
        .waddr   (flush ? '0 : wptr),
        .wdata   (bus.osd_colour),
        .raddr   (rptr),
        .rdata   (head)
    );

    always_comb begin
        state_nxt = (flush || udf_evt) ? PRIME
                  : (state == PRIME && level >= LW'(PRIME_LEVEL)) ? RUN
                  : state;
    end

    always_ff @(posedge spi_clk) begin
        if (reset) state <= PRIME;
        else       state <= state_nxt;
    end

    always_ff @(posedge spi_clk) begin
        if (reset) begin
            write_d      <= 1'b1;
            wptr         <= '0;
            rptr         <= '0;
            level        <= '0;
            pix_colour_q <= OSD_TRANSPARENT;
            pix_active_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            write_d     <= bus.write;
            wptr        <= flush ? PW'(push) : wptr + PW'(do_write);
            rptr        <= flush ? '0 : rptr + PW'(pop);
            level       <= flush ? LW'(push) : level + LW'(do_write) - LW'(pop);
            overflow_q  <= overflow_q | ovf_evt;
            underflow_q <= underflow_q | udf_evt;
            if (flush || udf_evt) begin
                pix_colour_q <= OSD_TRANSPARENT;
                pix_active_q <= 1'b0;
            end else if (pop) begin
                pix_colour_q <= head;
                pix_active_q <= head != OSD_TRANSPARENT;
            end
        end
    end

    assign bus.pix_colour = pix_colour_q;
    assign bus.pix_active = pix_active_q;
    assign bus.fifo_level = level;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;

`ifdef OSD_PIXEL_FIFO_STATS_EN
    logic [15:0] ovf_cnt, udf_cnt;

    always_ff @(posedge spi_clk) begin
        if (reset) begin
            ovf_cnt <= '0;
            udf_cnt <= '0;
        end else begin
            ovf_cnt <= ovf_cnt + 16'(ovf_evt && ovf_cnt != 16'hFFFF);
            udf_cnt <= udf_cnt + 16'(udf_evt && udf_cnt != 16'hFFFF);
        end
    end

    assign bus.ovf_count = ovf_cnt;
    assign bus.udf_count = udf_cnt;
`endif

endmodule

// File: tb/tb_osd_pixel_fifo.sv
// tb_osd_pixel_fifo: directed self-checking bench for osd_pixel_fifo (DEPTH=16, PRIME_LEVEL=4).
module tb_osd_pixel_fifo;

    logic spi_clk = 1'b0;
    logic reset   = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    always #5 spi_clk = ~spi_clk;

    osd_pixel_fifo_if #(.DEPTH(16)) bus ();

    osd_pixel_fifo #(.DEPTH(16), .PRIME_LEVEL(4)) dut (
        .spi_clk (spi_clk),
        .reset   (reset),
        .bus     (bus)
    );

    task automatic cyc();
        @(posedge spi_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] c);
        bus.osd_colour = c;
        bus.write      = 1'b0;
        cyc();
        bus.write      = 1'b1;
        cyc();
    endtask

    task automatic pop();
        bus.pix_en = 1'b1;
        cyc();
        bus.pix_en = 1'b0;
    endtask

    task automatic flush_line();
        bus.line_start = 1'b1;
        cyc();
        bus.line_start = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] c, input logic a, input logic [4:0] lvl);
        chk({tag, "_colour"}, 32'(bus.pix_colour), 32'(c));
        chk({tag, "_active"}, 32'(bus.pix_active), 32'(a));
        chk({tag, "_level"},  32'(bus.fifo_level), 32'(lvl));
    endtask

    initial begin
        logic [3:0] drain [16];
        bus.osd_colour = 4'h0;
        bus.write      = 1'b1;
        bus.line_start = 1'b0;
        bus.pix_en     = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        chk_out("reset", 4'h0, 1'b0, 5'd0);
        chk("reset_ovf", 32'(bus.overflow), 32'd0);
        chk("reset_udf", 32'(bus.underflow), 32'd0);
`ifdef OSD_PIXEL_FIFO_STATS_EN
        chk("reset_ovf_cnt", 32'(bus.ovf_count), 32'd0);
        chk("reset_udf_cnt", 32'(bus.udf_count), 32'd0);
`endif

        // in-order release of 3,5,7,9
        push(4'h3); push(4'h5); push(4'h7); push(4'h9);
        chk("fill4_level", 32'(bus.fifo_level), 32'd4);
        cyc();
        pop(); chk_out("pop3", 4'h3, 1'b1, 5'd3);
        pop(); chk_out("pop5", 4'h5, 1'b1, 5'd2);
        pop(); chk_out("pop7", 4'h7, 1'b1, 5'd1);
        pop(); chk_out("pop9", 4'h9, 1'b1, 5'd0);
        cyc(); chk_out("hold9", 4'h9, 1'b1, 5'd0);

        // underflow returns to PRIME; pix_en ignored until primed again
        pop();
        chk_out("udf", 4'h0, 1'b0, 5'd0);
        chk("udf_flag", 32'(bus.underflow), 32'd1);
        chk("udf_no_ovf", 32'(bus.overflow), 32'd0);
`ifdef OSD_PIXEL_FIFO_STATS_EN
        chk("udf_cnt1", 32'(bus.udf_count), 32'd1);
`endif
        push(4'h2); push(4'h4); push(4'h6);
        pop();
        chk_out("prime_ignore", 4'h0, 1'b0, 5'd3);
        push(4'h8);
        cyc();
        pop();
        chk_out("reprimed_pop", 4'h2, 1'b1, 5'd3);
        flush_line();
        chk_out("flush", 4'h0, 1'b0, 5'd0);
        chk("flush_udf_sticky", 32'(bus.underflow), 32'd1);

        // long write strobe stores once
        bus.osd_colour = 4'hA;
        bus.write      = 1'b0;
        cyc(); cyc(); cyc();
        bus.write      = 1'b1;
        cyc();
        chk("long_strobe_level", 32'(bus.fifo_level), 32'd1);
        flush_line();

        // fill to 16, then push+pop while full, then a dropped push
        for (int i = 0; i < 16; i++) push(4'((i % 15) + 1));
        chk("full_level", 32'(bus.fifo_level), 32'd16);
        chk("full_no_ovf", 32'(bus.overflow), 32'd0);
        bus.osd_colour = 4'hA; bus.write = 1'b0; bus.pix_en = 1'b1;
        cyc();
        bus.write = 1'b1; bus.pix_en = 1'b0;
        cyc();
        chk_out("full_pp1", 4'h1, 1'b1, 5'd16);
        bus.osd_colour = 4'hB; bus.write = 1'b0; bus.pix_en = 1'b1;
        cyc();
        bus.write = 1'b1; bus.pix_en = 1'b0;
        cyc();
        chk_out("full_pp2", 4'h2, 1'b1, 5'd16);
        chk("full_pp_no_ovf", 32'(bus.overflow), 32'd0);
        push(4'h5);
        chk("ovf_level", 32'(bus.fifo_level), 32'd16);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
`ifdef OSD_PIXEL_FIFO_STATS_EN
        chk("ovf_cnt1", 32'(bus.ovf_count), 32'd1);
`endif
        for (int i = 0; i < 13; i++) drain[i] = 4'(i + 3);
        drain[13] = 4'h1; drain[14] = 4'hA; drain[15] = 4'hB;
        for (int i = 0; i < 16; i++) begin
            pop();
            chk($sformatf("drain%0d", i), 32'(bus.pix_colour), 32'(drain[i]));
        end
        chk("drain_level", 32'(bus.fifo_level), 32'd0);

        // line_start with a push at level 6
        for (int i = 1; i <= 6; i++) push(4'(i));
        chk("lvl6", 32'(bus.fifo_level), 32'd6);
        bus.osd_colour = 4'hC; bus.write = 1'b0; bus.line_start = 1'b1;
        cyc();
        bus.write = 1'b1; bus.line_start = 1'b0;
        cyc();
        chk_out("ls_push", 4'h0, 1'b0, 5'd1);
        pop();
        chk_out("ls_prime_ignore", 4'h0, 1'b0, 5'd1);
        push(4'hD); push(4'hE); push(4'h7);
        cyc();
        pop();
        chk_out("ls_head_c", 4'hC, 1'b1, 5'd3);

        // line_start with pix_en: flush wins, no underflow event
        bus.line_start = 1'b1; bus.pix_en = 1'b1;
        cyc();
        bus.line_start = 1'b0; bus.pix_en = 1'b0;
        chk_out("ls_pix_en", 4'h0, 1'b0, 5'd0);
`ifdef OSD_PIXEL_FIFO_STATS_EN
        chk("ls_udf_cnt", 32'(bus.udf_count), 32'd1);
`endif

        // reset mid-operation, with a write strobe active
        push(4'h3); push(4'h4);
        bus.write = 1'b0; reset = 1'b1;
        cyc();
        reset = 1'b0; bus.write = 1'b1;
        chk_out("midreset", 4'h0, 1'b0, 5'd0);
        chk("midreset_ovf", 32'(bus.overflow), 32'd0);
        chk("midreset_udf", 32'(bus.underflow), 32'd0);
`ifdef OSD_PIXEL_FIFO_STATS_EN
        chk("midreset_ovf_cnt", 32'(bus.ovf_count), 32'd0);
        chk("midreset_udf_cnt", 32'(bus.udf_count), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
